// File: rtl/sram_byte_access_master.sv
// Byte-addressed request/response front end for the byte-enabled single-port SRAM.
// One request in flight; sub-word reads are lane-extracted and zero-extended.
module sram_byte_access_master #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 7,
    localparam int unsigned BE_W            = DATA_WIDTH / 8,
    localparam int unsigned LANE_BITS       = $clog2(DATA_WIDTH / 8),
    localparam int unsigned BYTE_ADDR_WIDTH = ADDRESS_WIDTH + LANE_BITS
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic                       i_req_write,
    input  logic [BYTE_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]                 i_req_size,
    input  logic [31:0]                i_req_wdata,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [31:0]                o_rsp_rdata,
    output logic                       o_rsp_error,
    output logic [ADDRESS_WIDTH-1:0]   o_sram_address,
    output logic                       o_sram_write_enable,
    output logic [BE_W-1:0]            o_sram_byte_enable,
    output logic [DATA_WIDTH-1:0]      o_sram_write_data,
    input  logic [DATA_WIDTH-1:0]      i_sram_read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RDATA  = 2'd2;
    localparam logic [1:0] RSP    = 2'd3;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [LANE_BITS-1:0]     lane_q;
    logic [1:0]               size_q;
    logic                     write_q;
    logic                     we_q;

    logic                     req_fire;
    logic                     req_err;
    logic [LANE_BITS-1:0]     req_lane;
    logic [ADDRESS_WIDTH-1:0] req_word;
    logic [3:0]               req_nbytes;
    logic [DATA_WIDTH-1:0]    rd_shift;

    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 32'h0000_00FF;
            2'd1:    size_mask = 32'h0000_FFFF;
            default: size_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] size_be(input logic [1:0] size);
        case (size)
            2'd0:    size_be = BE_W'(1);
            2'd1:    size_be = BE_W'(3);
            default: size_be = BE_W'(15);
        endcase
    endfunction

    // Reset overrides the registered handshake/strobe so an ACCESS-cycle write is aborted
    assign o_req_ready         = (state == IDLE) && !i_rst;
    assign o_sram_write_enable = we_q && !i_rst;
    assign req_fire            = i_req_valid && o_req_ready;

    always_comb begin
        req_lane   = i_req_addr[LANE_BITS-1:0];
        req_word   = i_req_addr[BYTE_ADDR_WIDTH-1:LANE_BITS];
        req_nbytes = 4'd1 << i_req_size;
        req_err    = (i_req_size == 2'd3)
                  || ((LANE_BITS'(req_nbytes - 4'd1) & req_lane) != '0)
                  || (32'(req_nbytes) > BE_W);
        rd_shift   = i_sram_read_data >> {lane_q, 3'b000};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = req_err ? RSP : ACCESS;
            ACCESS:  state_nxt = write_q ? RSP : RDATA;
            RDATA:   state_nxt = RSP;
            RSP:     if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and response registers; SRAM address/lanes/data hold between accesses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lane_q             <= '0;
            size_q             <= '0;
            write_q            <= 1'b0;
            we_q               <= 1'b0;
            o_rsp_valid        <= 1'b0;
            o_rsp_error        <= 1'b0;
            o_rsp_rdata        <= '0;
            o_sram_address     <= '0;
            o_sram_byte_enable <= '0;
            o_sram_write_data  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        lane_q  <= req_lane;
                        size_q  <= i_req_size;
                        write_q <= i_req_write;
                        if (req_err) begin
                            o_rsp_valid <= 1'b1;
                            o_rsp_error <= 1'b1;
                            o_rsp_rdata <= '0;
                        end else begin
                            we_q               <= i_req_write;
                            o_sram_address     <= req_word;
                            o_sram_byte_enable <= size_be(i_req_size) << req_lane;
                            o_sram_write_data  <= DATA_WIDTH'(i_req_wdata & size_mask(i_req_size))
                                                  << {req_lane, 3'b000};
                        end
                    end
                end
                ACCESS: begin
                    if (write_q) begin
                        o_rsp_valid <= 1'b1;
                        o_rsp_error <= 1'b0;
                        o_rsp_rdata <= '0;
                    end
                end
                RDATA: begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_error <= 1'b0;
                    o_rsp_rdata <= 32'(rd_shift) & size_mask(size_q);
                end
                RSP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_error <= 1'b0;
                        o_rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_byte_access_master.sv
// Directed bench for sram_byte_access_master with a behavioural SRAM and a response scoreboard.
module tb_sram_byte_access_master;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [8:0]  i_req_addr = '0;
    logic [1:0]  i_req_size = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_error;
    logic [6:0]  o_sram_address;
    logic        o_sram_write_enable;
    logic [3:0]  o_sram_byte_enable;
    logic [31:0] o_sram_write_data;
    logic [31:0] i_sram_read_data = '0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [128];
    int          vectors = 0;
    int          miscompares = 0;
    int          we_cnt = 0;

    sram_byte_access_master dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_req_valid         (i_req_valid),
        .o_req_ready         (o_req_ready),
        .i_req_write         (i_req_write),
        .i_req_addr          (i_req_addr),
        .i_req_size          (i_req_size),
        .i_req_wdata         (i_req_wdata),
        .o_rsp_valid         (o_rsp_valid),
        .i_rsp_ready         (i_rsp_ready),
        .o_rsp_rdata         (o_rsp_rdata),
        .o_rsp_error         (o_rsp_error),
        .o_sram_address      (o_sram_address),
        .o_sram_write_enable (o_sram_write_enable),
        .o_sram_byte_enable  (o_sram_byte_enable),
        .o_sram_write_data   (o_sram_write_data),
        .i_sram_read_data    (i_sram_read_data)
    );

    always #5 i_clk = ~i_clk;

    // Byte-enabled SRAM: read word appears one cycle after the address
    always @(posedge i_clk) begin
        if (o_sram_write_enable) begin
            we_cnt <= we_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (o_sram_byte_enable[b]) mem[o_sram_address][8*b +: 8] <= o_sram_write_data[8*b +: 8];
        end
        i_sram_read_data <= mem[o_sram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [8:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic push,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int n = 0;
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_size  = size;
        i_req_wdata = wdata;
        while (!o_req_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("req_ready_wait", 32'(o_req_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        if (push) sb.push_back('{err: exp_err, rdata: exp_rdata});
    endtask

    task automatic wait_rsp(input int start, input int exp_lat, input string tag);
        int   lat = start;
        exp_t e;
        do begin
            @(negedge i_clk);
            lat++;
        end while (!o_rsp_valid && lat < 12);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_error"}, 32'(o_rsp_error), 32'(e.err));
            chk({tag, "_rdata"}, o_rsp_rdata, e.rdata);
        end
    endtask

    task automatic consume();
        @(negedge i_clk);
        i_rsp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  snap_addr;
        logic [3:0]  snap_be;
        logic [31:0] snap_wd;
        int          snap_we;

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[1] = 32'h1122_3344;
        mem[2] = 32'h5566_7788;

        // Reset and idle
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        chk("rst_we", 32'(o_sram_write_enable), 32'd0);
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("idle_req_ready", 32'(o_req_ready), 32'd1);
            chk("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);
            chk("idle_rsp_error", 32'(o_rsp_error), 32'd0);
            chk("idle_rsp_rdata", o_rsp_rdata, 32'd0);
            chk("idle_sram_addr", 32'(o_sram_address), 32'd0);
            chk("idle_sram_be", 32'(o_sram_byte_enable), 32'd0);
            chk("idle_sram_wd", o_sram_write_data, 32'd0);
            chk("idle_sram_we", 32'(o_sram_write_enable), 32'd0);
        end

        // Byte write into lane 1 of word 1
        send(1'b1, 9'h005, 2'd0, 32'h0000_FFA5, 1'b1, 1'b0, 32'h0);
        @(negedge i_clk);
        chk("w8_addr", 32'(o_sram_address), 32'd1);
        chk("w8_be", 32'(o_sram_byte_enable), 32'h2);
        chk("w8_wd", o_sram_write_data, 32'h0000_A500);
        chk("w8_we", 32'(o_sram_write_enable), 32'd1);
        wait_rsp(1, 2, "w8");
        chk("w8_we_after", 32'(o_sram_write_enable), 32'd0);
        consume();
        chk("w8_mem", mem[1], 32'h1122_A544);

        // Reads of each size
        send(1'b0, 9'h006, 2'd1, 32'h0, 1'b1, 1'b0, 32'h0000_1122);
        @(negedge i_clk);
        chk("r16_addr", 32'(o_sram_address), 32'd1);
        chk("r16_we", 32'(o_sram_write_enable), 32'd0);
        wait_rsp(1, 3, "r16");
        consume();
        send(1'b0, 9'h005, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0000_00A5);
        wait_rsp(0, 3, "r8");
        consume();
        send(1'b0, 9'h004, 2'd2, 32'h0, 1'b1, 1'b0, 32'h1122_A544);
        wait_rsp(0, 3, "r32");
        consume();

        // Misaligned and illegal-size requests leave the SRAM port alone
        snap_addr = o_sram_address;
        snap_be   = o_sram_byte_enable;
        snap_wd   = o_sram_write_data;
        snap_we   = we_cnt;
        send(1'b0, 9'h003, 2'd1, 32'h0, 1'b1, 1'b1, 32'h0);
        wait_rsp(0, 1, "err_misalign");
        consume();
        send(1'b1, 9'h000, 2'd3, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0);
        wait_rsp(0, 1, "err_size3");
        consume();
        chk("err_sram_addr", 32'(o_sram_address), 32'(snap_addr));
        chk("err_sram_be", 32'(o_sram_byte_enable), 32'(snap_be));
        chk("err_sram_wd", o_sram_write_data, snap_wd);
        chk("err_we_cnt", 32'(we_cnt), 32'(snap_we));

        // Response backpressure, then back-to-back accept after the handshake
        send(1'b0, 9'h004, 2'd2, 32'h0, 1'b1, 1'b0, 32'h1122_A544);
        wait_rsp(0, 3, "bp_r32");
        repeat (5) begin
            @(negedge i_clk);
            chk("bp_valid", 32'(o_rsp_valid), 32'd1);
            chk("bp_rdata", o_rsp_rdata, 32'h1122_A544);
            chk("bp_error", 32'(o_rsp_error), 32'd0);
            chk("bp_req_ready", 32'(o_req_ready), 32'd0);
        end
        consume();
        chk("post_hs_req_ready", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_write = 1'b0;
        i_req_addr  = 9'h007;
        i_req_size  = 2'd0;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        sb.push_back('{err: 1'b0, rdata: 32'h0000_0011});
        wait_rsp(0, 3, "b2b_r8");
        consume();

        // Reset during the ACCESS cycle of a write aborts it
        send(1'b1, 9'h008, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort_we", 32'(o_sram_write_enable), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("abort_req_ready", 32'(o_req_ready), 32'd1);
            chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
        end
        chk("abort_mem", mem[2], 32'h5566_7788);
        chk("total_we_pulses", 32'(we_cnt), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_byte_access_master.md
Name: sram_byte_access_master

Overview:
- Initiator for the byte-enabled single-port SRAM used throughout the codebase.
- Accepts byte-addressed 8/16/32-bit read and write requests on a valid/ready port, one at a time.
- Converts each request into a word address, byte enables and a lane-aligned write word on the SRAM port.
- Returns read data extracted from the correct byte lanes and zero-extended, on a valid/ready response port; misaligned or oversized requests complete with an error and no SRAM access.

Parameters:
DATA_WIDTH, 32, SRAM word width in bits; multiple of 8, minimum 32.
ADDRESS_WIDTH, 7, SRAM word-address width.
(local) LANE_BITS = $clog2(DATA_WIDTH/8); BYTE_ADDR_WIDTH = ADDRESS_WIDTH + LANE_BITS.

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&&ready
i_req_write  in  1  1=write, 0=read
i_req_addr  in  BYTE_ADDR_WIDTH  byte address
i_req_size  in  2  0=8b, 1=16b, 2=32b, 3=illegal
i_req_wdata  in  32  write data, right-justified
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed when valid&&ready
o_rsp_rdata  out  32  read data, zero-extended; 0 for writes/errors
o_rsp_error  out  1  request rejected (misaligned/illegal size)
o_sram_address  out  ADDRESS_WIDTH  word address
o_sram_write_enable  out  1  write strobe
o_sram_byte_enable  out  DATA_WIDTH/8  byte lane enables
o_sram_write_data  out  DATA_WIDTH  lane-aligned write word
i_sram_read_data  in  DATA_WIDTH  SRAM read word, valid one cycle after address

Behaviour:
- Reset: state IDLE; o_req_ready=0 during reset cycle, 1 afterwards; o_rsp_valid, o_rsp_error, o_rsp_rdata, o_sram_* all 0.
- States: IDLE, ACCESS, RDATA, RSP. o_req_ready = (state==IDLE). Exactly one request outstanding.
- Derived on accept: lane = addr[LANE_BITS-1:0]; nbytes = 1<<size; word = addr[BYTE_ADDR_WIDTH-1:LANE_BITS].
- Error if size==3, or (lane mod nbytes)!=0, or nbytes > DATA_WIDTH/8.
- IDLE, accept with error: go to RSP next cycle with error=1, rdata=0; SRAM outputs untouched, write_enable stays 0.
- IDLE, accept legal: register o_sram_address=word; o_sram_byte_enable=((1<<nbytes)-1)<<lane; o_sram_write_data = (wdata masked to nbytes) << 8*lane, other bits 0; o_sram_write_enable=i_req_write. Go to ACCESS.
- ACCESS (exactly 1 cycle): SRAM samples at end of cycle; write_enable returns to 0 on the next edge. Write → RSP (rdata 0, error 0); read → RDATA.
- RDATA: capture rdata = (i_sram_read_data >> 8*lane) masked to nbytes, zero-extended to 32; → RSP.
- RSP: o_rsp_valid=1, payload stable until i_rsp_ready; on handshake clear valid/error/rdata, → IDLE. Next request can be accepted the cycle after the response handshake.
- Latency from accept edge to o_rsp_valid: error 1 cycle, write 2 cycles, read 3 cycles.
- o_sram_address, byte_enable and write_data hold their last values when not in ACCESS. Write_enable is high only in ACCESS for writes.
- Reset in any state: returns to IDLE on that edge, write_enable forced 0 and pending response dropped. A write in ACCESS is aborted if reset coincides.
- Widths: byte-enable/shift arithmetic sized to DATA_WIDTH; wdata bits above nbytes*8 ignored.

Test Plan:
- Reset, then 3 idle cycles → o_req_ready=1 from first post-reset cycle; all other outputs 0, write_enable never asserted.
- Preload SRAM word 1=0x11223344; write8 addr 0x05 data 0xFFA5 → one cycle: address 1, byte_enable 0b0010, write_data 0x0000A500, write_enable=1. Response 2 cycles after accept, rdata 0. Word becomes 0x1122A544.
- Read16 addr 0x06 → address 1, write_enable 0, rsp 3 cycles after accept, rdata 0x00001122. Read8 addr 0x05 → 0x000000A5. Read32 addr 0x04 → 0x1122A544.
- Read16 addr 0x03, and size=3 at addr 0 → error=1, rdata 0, rsp 1 cycle after accept, no change on SRAM outputs.
- Read32 with i_rsp_ready held low 5 cycles → o_rsp_valid and payload stable, o_req_ready=0 throughout. Next request accepted the cycle after the handshake.
- Assert i_rst during ACCESS of a write to addr 0x08 → write_enable 0 at that edge, word 2 unchanged, no response emitted, o_req_ready=1 after reset.
